tdm_nco_sequencer: RTL and testbench

- **Role:** drives the address side of the TDM wavetable reader, i.e. its `nco_addr_in`, `is_chan_en` and `channel_num` inputs.
- **Per-voice state:** a phase accumulator and a tuning word for each voice.
- **Per sample tick:** sweeps every voice, one voice per clock. For each voice it emits the top phase bits as a wavetable address, tagged with the voice number and enable flag, then advances that voice's phase.
- **Configuration:** a simple write port loads tuning words and enables, and resets phases.

---
 rtl/synth_pkg.sv | 19 +
 rtl/tdm_nco_sequencer_regfile.sv | 77 +++++++
 rtl/tdm_nco_sequencer.sv | 144 ++++++++++++++
 tb/tb_tdm_nco_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the TDM synthesiser voice path.
package synth_pkg;

    localparam int VOICES_DEF      = 4;
    localparam int VOICES_BITS_DEF = 2;
    localparam int PHASE_W_DEF     = 24;
    localparam int ADDR_W_DEF      = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } seq_state_e;

    localparam logic [1:0] WAVE_SIN = 2'd0;
    localparam logic [1:0] WAVE_TRI = 2'd1;
    localparam logic [1:0] WAVE_SQR = 2'd2;
    localparam logic [1:0] WAVE_SAW = 2'd3;

endpackage

// File: rtl/tdm_nco_sequencer_regfile.sv
// Per-voice phase / tuning word / enable storage with sweep and config ports.
module tdm_phase_regfile
    import synth_pkg::*;
#(
    parameter int VOICES      = VOICES_DEF,
    parameter int VOICES_BITS = VOICES_BITS_DEF,
    parameter int PHASE_W     = PHASE_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [VOICES_BITS-1:0] rd_slot_i,
    output logic [PHASE_W-1:0]     rd_phase_o,
    output logic [PHASE_W-1:0]     rd_tw_o,
    output logic                   rd_en_o,
    input  logic                   wr_en_i,
    input  logic [VOICES_BITS-1:0] wr_slot_i,
    input  logic [PHASE_W-1:0]     wr_phase_i,
    input  logic                   cfg_we_i,
    input  logic [VOICES_BITS-1:0] cfg_chan_i,
    input  logic [PHASE_W-1:0]     cfg_tw_i,
    input  logic                   cfg_en_i,
    input  logic                   cfg_phase_rst_i
);

    logic [PHASE_W-1:0] phase_q [VOICES];
    logic [PHASE_W-1:0] phase_d [VOICES];
    logic [PHASE_W-1:0] tw_q    [VOICES];
    logic [PHASE_W-1:0] tw_d    [VOICES];
    logic               en_q    [VOICES];
    logic               en_d    [VOICES];

    // Reads see the pre-edge values, so a colliding config write only lands after the read.
    assign rd_phase_o = phase_q[rd_slot_i];
    assign rd_tw_o    = tw_q[rd_slot_i];
    assign rd_en_o    = en_q[rd_slot_i];

    // Next-state per voice: a phase clear from config beats the sweep accumulate.
    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            phase_d[v] = phase_q[v];
            tw_d[v]    = tw_q[v];
            en_d[v]    = en_q[v];
            if (cfg_we_i && (cfg_chan_i == VOICES_BITS'(v))) begin
                tw_d[v] = cfg_tw_i;
                en_d[v] = cfg_en_i;
            end else begin
                tw_d[v] = tw_q[v];
                en_d[v] = en_q[v];
            end
            if (cfg_we_i && cfg_phase_rst_i && (cfg_chan_i == VOICES_BITS'(v))) begin
                phase_d[v] = {PHASE_W{1'b0}};
            end else if (wr_en_i && (wr_slot_i == VOICES_BITS'(v))) begin
                phase_d[v] = wr_phase_i;
            end else begin
                phase_d[v] = phase_q[v];
            end
        end
    end

    // Storage registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v] <= {PHASE_W{1'b0}};
                tw_q[v]    <= {PHASE_W{1'b0}};
                en_q[v]    <= 1'b0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v] <= phase_d[v];
                tw_q[v]    <= tw_d[v];
                en_q[v]    <= en_d[v];
            end
        end
    end

endmodule

// File: rtl/tdm_nco_sequencer.sv
// Sweeps every voice once per sample tick, emitting wavetable addresses in TDM slots.
module tdm_nco_sequencer
    import synth_pkg::*;
#(
    parameter int VOICES      = VOICES_DEF,
    parameter int VOICES_BITS = VOICES_BITS_DEF,
    parameter int PHASE_W     = PHASE_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   tick,
    input  logic                   cfg_we,
    input  logic [VOICES_BITS-1:0] cfg_chan,
    input  logic [PHASE_W-1:0]     cfg_tw,
    input  logic                   cfg_en,
    input  logic                   cfg_phase_rst,
    output logic [ADDR_W-1:0]      nco_addr_out,
    output logic                   chan_en_out,
    output logic [VOICES_BITS-1:0] chan_num_out,
    output logic                   addr_valid,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam logic [VOICES_BITS-1:0] LAST_SLOT = VOICES_BITS'(VOICES - 1);
    localparam logic [VOICES_BITS-1:0] SLOT_ONE  = {{(VOICES_BITS-1){1'b0}}, 1'b1};

    seq_state_e             state_q, state_d;
    logic [VOICES_BITS-1:0] slot_q, slot_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   chan_en_q, chan_en_d;
    logic [VOICES_BITS-1:0] chan_num_q, chan_num_d;
    logic                   valid_q, valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overrun_q, overrun_d;

    logic [PHASE_W-1:0]     rd_phase_s;
    logic [PHASE_W-1:0]     rd_tw_s;
    logic                   rd_en_s;
    logic                   sweep_we_s;
    logic [PHASE_W-1:0]     sweep_phase_s;

    assign sweep_phase_s = rd_phase_s + rd_tw_s;

    tdm_phase_regfile #(
        .VOICES      (VOICES),
        .VOICES_BITS (VOICES_BITS),
        .PHASE_W     (PHASE_W)
    ) u_regfile (
        .clk_i           (sys_clk),
        .rst_n_i         (sys_rst_n),
        .rd_slot_i       (slot_q),
        .rd_phase_o      (rd_phase_s),
        .rd_tw_o         (rd_tw_s),
        .rd_en_o         (rd_en_s),
        .wr_en_i         (sweep_we_s),
        .wr_slot_i       (slot_q),
        .wr_phase_i      (sweep_phase_s),
        .cfg_we_i        (cfg_we),
        .cfg_chan_i      (cfg_chan),
        .cfg_tw_i        (cfg_tw),
        .cfg_en_i        (cfg_en),
        .cfg_phase_rst_i (cfg_phase_rst)
    );

    // Sweep FSM: next state, slot counter, output register inputs and overrun.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        addr_d       = addr_q;
        chan_en_d    = chan_en_q;
        chan_num_d   = chan_num_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        sweep_we_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SWEEP;
                    slot_d  = {VOICES_BITS{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                addr_d       = rd_phase_s[PHASE_W-1 -: ADDR_W];
                chan_en_d    = rd_en_s;
                chan_num_d   = slot_q;
                valid_d      = 1'b1;
                frame_done_d = (slot_q == LAST_SLOT);
                sweep_we_s   = rd_en_s;
                if (slot_q == LAST_SLOT) begin
                    state_d = ST_IDLE;
                    slot_d  = {VOICES_BITS{1'b0}};
                end else begin
                    slot_d  = slot_q + SLOT_ONE;
                end
                // A tick during a sweep is dropped, but remembered until reset.
                if (tick) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = {VOICES_BITS{1'b0}};
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            slot_q       <= {VOICES_BITS{1'b0}};
            addr_q       <= {ADDR_W{1'b0}};
            chan_en_q    <= 1'b0;
            chan_num_q   <= {VOICES_BITS{1'b0}};
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            addr_q       <= addr_d;
            chan_en_q    <= chan_en_d;
            chan_num_q   <= chan_num_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign nco_addr_out = addr_q;
    assign chan_en_out  = chan_en_q;
    assign chan_num_out = chan_num_q;
    assign addr_valid   = valid_q;
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tdm_nco_sequencer.sv
// Directed-vector bench for tdm_nco_sequencer with hand-computed expectations.
module tb_tdm_nco_sequencer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        tick;
    logic        cfg_we;
    logic [1:0]  cfg_chan;
    logic [23:0] cfg_tw;
    logic        cfg_en;
    logic        cfg_phase_rst;
    logic [7:0]  nco_addr_out;
    logic        chan_en_out;
    logic [1:0]  chan_num_out;
    logic        addr_valid;
    logic        frame_done;
    logic        overrun;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] cap_addr  [4];
    logic       cap_en    [4];
    logic [1:0] cap_num   [4];
    logic       cap_valid [4];
    logic       cap_fd    [4];
    logic       post_valid;

    always #5 sys_clk = ~sys_clk;

    tdm_nco_sequencer dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .tick          (tick),
        .cfg_we        (cfg_we),
        .cfg_chan      (cfg_chan),
        .cfg_tw        (cfg_tw),
        .cfg_en        (cfg_en),
        .cfg_phase_rst (cfg_phase_rst),
        .nco_addr_out  (nco_addr_out),
        .chan_en_out   (chan_en_out),
        .chan_num_out  (chan_num_out),
        .addr_valid    (addr_valid),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [23:0] tw, input logic en, input logic prst);
        cfg_we = 1'b1; cfg_chan = ch; cfg_tw = tw; cfg_en = en; cfg_phase_rst = prst;
        step();
        cfg_we = 1'b0; cfg_phase_rst = 1'b0;
    endtask

    // One tick, capture the four slots, then the cycle after; 10-cycle frame spacing.
    task automatic run_frame(input bit do_cfg, input int cfg_slot, input logic [1:0] ch,
                             input logic [23:0] tw, input logic en, input logic prst);
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (do_cfg && s == cfg_slot) begin
                cfg_we = 1'b1; cfg_chan = ch; cfg_tw = tw; cfg_en = en; cfg_phase_rst = prst;
            end
            step();
            cfg_we = 1'b0; cfg_phase_rst = 1'b0;
            cap_addr[s] = nco_addr_out; cap_en[s] = chan_en_out; cap_num[s] = chan_num_out;
            cap_valid[s] = addr_valid; cap_fd[s] = frame_done;
        end
        step();
        post_valid = addr_valid;
        repeat (4) step();
    endtask

    task automatic frame();
        run_frame(1'b0, 0, 2'd0, 24'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) step();
        vectors++; if (nco_addr_out !== 8'h00) begin errors++; $display("FAIL reset addr: got %h want 00", nco_addr_out); end
        vectors++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", addr_valid); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b want 0", overrun); end
        sys_rst_n = 1'b1;
        cfg_write(2'd0, 24'h800000, 1'b1, 1'b0);
        cfg_write(2'd1, 24'h010000, 1'b1, 1'b0);
        frame();
        // Reset asserted mid-sweep while slot 2 is on the outputs.
        tick = 1'b1; step(); tick = 1'b0;
        repeat (3) step();
        vectors++; if (chan_num_out !== 2'd2 || addr_valid !== 1'b1) begin errors++;
            $display("FAIL midsweep slot: got num=%0d valid=%b want num=2 valid=1", chan_num_out, addr_valid); end
        #2 sys_rst_n = 1'b0;
        #1;
        vectors++; if (nco_addr_out !== 8'h00 || chan_en_out !== 1'b0 || chan_num_out !== 2'd0) begin errors++;
            $display("FAIL async reset data: got addr=%h en=%b num=%0d want 00 0 0", nco_addr_out, chan_en_out, chan_num_out); end
        vectors++; if (addr_valid !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin errors++;
            $display("FAIL async reset flags: got valid=%b fd=%b ovr=%b want 0 0 0", addr_valid, frame_done, overrun); end
        step();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL post-reset idle c%0d valid: got %b want 0", i, addr_valid); end
        end
        frame();
        for (int s = 0; s < 4; s++) begin
            vectors++; if (cap_addr[s] !== 8'h00 || cap_en[s] !== 1'b0) begin errors++;
                $display("FAIL first frame slot%0d: got addr=%h en=%b want 00 0", s, cap_addr[s], cap_en[s]); end
        end
    endtask

    task automatic test_steady();
        cfg_write(2'd1, 24'h010000, 1'b1, 1'b0);
        for (int f = 0; f < 4; f++) begin
            logic [7:0] exp_addr;
            exp_addr = 8'(f);
            frame();
            vectors++; if (cap_addr[1] !== exp_addr || cap_en[1] !== 1'b1) begin errors++;
                $display("FAIL steady f%0d v1: got addr=%h en=%b want %h 1", f, cap_addr[1], cap_en[1], exp_addr); end
            for (int s = 0; s < 4; s++) begin
                logic [1:0] exp_num;
                logic       exp_fd;
                exp_num = 2'(s);
                exp_fd  = (s == 3);
                vectors++; if (cap_num[s] !== exp_num || cap_valid[s] !== 1'b1 || cap_fd[s] !== exp_fd) begin errors++;
                    $display("FAIL steady f%0d slot%0d: got num=%0d valid=%b fd=%b want %0d 1 %b",
                             f, s, cap_num[s], cap_valid[s], cap_fd[s], exp_num, exp_fd); end
            end
            vectors++; if (post_valid !== 1'b0) begin errors++; $display("FAIL steady f%0d tail valid: got %b want 0", f, post_valid); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr [3];
        exp_addr[0] = 8'h00; exp_addr[1] = 8'h80; exp_addr[2] = 8'h00;
        cfg_write(2'd0, 24'h800000, 1'b1, 1'b1);
        for (int f = 0; f < 3; f++) begin
            frame();
            vectors++; if (cap_addr[0] !== exp_addr[f]) begin errors++;
                $display("FAIL wrap f%0d v0 addr: got %h want %h", f, cap_addr[0], exp_addr[f]); end
        end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL wrap overrun: got %b want 0", overrun); end
    endtask

    task automatic test_disabled();
        logic [7:0] exp_addr [2];
        exp_addr[0] = 8'h00; exp_addr[1] = 8'h04;
        cfg_write(2'd2, 24'h040000, 1'b0, 1'b1);
        for (int f = 0; f < 2; f++) begin
            frame();
            vectors++; if (cap_addr[2] !== 8'h00 || cap_en[2] !== 1'b0) begin errors++;
                $display("FAIL disabled f%0d v2: got addr=%h en=%b want 00 0", f, cap_addr[2], cap_en[2]); end
        end
        cfg_write(2'd2, 24'h040000, 1'b1, 1'b0);
        for (int f = 0; f < 2; f++) begin
            frame();
            vectors++; if (cap_addr[2] !== exp_addr[f] || cap_en[2] !== 1'b1) begin errors++;
                $display("FAIL enabled f%0d v2: got addr=%h en=%b want %h 1", f, cap_addr[2], cap_en[2], exp_addr[f]); end
        end
    endtask

    task automatic test_collision();
        cfg_write(2'd3, 24'h010000, 1'b1, 1'b1);
        repeat (5) frame();
        vectors++; if (cap_addr[3] !== 8'h04) begin errors++; $display("FAIL collision setup v3: got %h want 04", cap_addr[3]); end
        run_frame(1'b1, 3, 2'd3, 24'h020000, 1'b1, 1'b1);
        vectors++; if (cap_addr[3] !== 8'h05 || cap_en[3] !== 1'b1) begin errors++;
            $display("FAIL collision slot v3: got addr=%h en=%b want 05 1", cap_addr[3], cap_en[3]); end
        frame();
        vectors++; if (cap_addr[3] !== 8'h00) begin errors++; $display("FAIL collision next v3: got %h want 00", cap_addr[3]); end
        frame();
        vectors++; if (cap_addr[3] !== 8'h02) begin errors++; $display("FAIL collision after v3: got %h want 02", cap_addr[3]); end
    endtask

    task automatic test_overrun();
        int nvalid;
        nvalid = 0;
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun pre: got %b want 0", overrun); end
        tick = 1'b1; step(); tick = 1'b0;
        step(); if (addr_valid === 1'b1) nvalid++;
        tick = 1'b1; step(); tick = 1'b0;
        if (addr_valid === 1'b1) nvalid++;
        for (int i = 0; i < 8; i++) begin
            step();
            if (addr_valid === 1'b1) nvalid++;
        end
        vectors++; if (nvalid !== 4) begin errors++; $display("FAIL overrun valid slots: got %0d want 4", nvalid); end
        vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun set: got %b want 1", overrun); end
        frame();
        vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun sticky: got %b want 1", overrun); end
        vectors++; if (cap_valid[0] !== 1'b1 || cap_fd[3] !== 1'b1) begin errors++;
            $display("FAIL overrun later frame: got valid0=%b fd3=%b want 1 1", cap_valid[0], cap_fd[3]); end
    endtask

    initial begin
        sys_rst_n = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_chan = 2'd0;
        cfg_tw = 24'h0; cfg_en = 1'b0; cfg_phase_rst = 1'b0;
        test_reset();
        test_steady();
        test_wrap();
        test_disabled();
        test_collision();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
